// File: rtl/fifo_push_scheduler.sv
// Round-robin push scheduler: shares one downstream FIFO between NUM_REQ producers with per-producer quota and drain/flush.
// Define FIFO_PUSH_SCHEDULER_STATS_EN to add the stall_cnt_o stall-cycle counter port.
module fifo_push_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int QUOTA      = 2,
  localparam int IDW       = $clog2(NUM_REQ),
  localparam int CW        = $clog2(QUOTA + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_push_o,
  output logic [IDW+DATA_WIDTH-1:0]     fifo_data_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_empty_i,
  input  logic                          fifo_pop_i,
  input  logic [IDW-1:0]                fifo_pop_id_i,
  input  logic                          drain_i,
  output logic                          fifo_flush_o,
`ifdef FIFO_PUSH_SCHEDULER_STATS_EN
  output logic [31:0]                   stall_cnt_o,
`endif
  output logic                          busy_o
);

  localparam int SW = IDW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

  state_t               state_q;
  logic [IDW-1:0]       rr_q;
  logic [IDW-1:0]       win;
  logic                 found;
  logic [NUM_REQ-1:0]   elig;

  // Per-producer occupancy counters; a grant and a matching pop in one cycle cancel.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      logic [CW-1:0] cnt_q;
      logic          inc;
      logic          dec;

      assign inc      = req_ready_o[gi];
      assign dec      = fifo_pop_i && (fifo_pop_id_i == IDW'(gi));
      assign elig[gi] = req_valid_i[gi] && (cnt_q < CW'(QUOTA)) &&
                        (state_q == RUN) && !fifo_full_i;

      always_ff @(posedge clk_i) begin
        if (rst_i || state_q == FLUSH) begin
          cnt_q <= '0;
        end else if (inc && !dec) begin
          cnt_q <= cnt_q + 1'b1;
        end else if (dec && !inc && cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  endgenerate

  // Search eligible producers starting at rr_q, wrapping at NUM_REQ (not necessarily a power of two).
  always_comb begin
    logic [SW-1:0] idx;
    found       = 1'b0;
    win         = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + SW'(k);
      if (idx >= SW'(NUM_REQ)) idx = idx - SW'(NUM_REQ);
      if (!found && elig[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
    if (found) req_ready_o[win] = 1'b1;
  end

  assign fifo_push_o  = found;
  assign fifo_data_o  = found ? {win, req_data_i[win*DATA_WIDTH +: DATA_WIDTH]} : '0;
  assign fifo_flush_o = (state_q == FLUSH);
  assign busy_o       = (state_q != RUN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      rr_q    <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (found) rr_q <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          if (drain_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty_i && !fifo_pop_i) state_q <= FLUSH;
        end
        FLUSH: begin
          state_q <= RUN;
          rr_q    <= '0;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef FIFO_PUSH_SCHEDULER_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == FLUSH) begin
      stall_cnt_o <= '0;
    end else if ((|req_valid_i) && !fifo_push_o && stall_cnt_o != 32'hFFFF_FFFF) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_push_scheduler.sv
// Scoreboard bench for fifo_push_scheduler: a queue-based reference model predicts each cycle's outputs.
module tb_fifo_push_scheduler;
  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int Q   = 2;
  localparam int IDW = 2;
  localparam int CAP = 8;
  localparam int M_RUN = 0, M_DRAIN = 1, M_FLUSH = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NR-1:0]        req_valid_i;
  logic [NR*DW-1:0]     req_data_i;
  logic [NR-1:0]        req_ready_o;
  logic                 fifo_push_o;
  logic [IDW+DW-1:0]    fifo_data_o;
  logic                 fifo_full_i, fifo_empty_i, fifo_pop_i;
  logic [IDW-1:0]       fifo_pop_id_i;
  logic                 drain_i;
  logic                 fifo_flush_o;
  logic                 busy_o;
`ifdef FIFO_PUSH_SCHEDULER_STATS_EN
  logic [31:0]          stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  fifo_push_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .QUOTA(Q)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .fifo_push_o(fifo_push_o), .fifo_data_o(fifo_data_o),
    .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
    .fifo_pop_i(fifo_pop_i), .fifo_pop_id_i(fifo_pop_id_i),
    .drain_i(drain_i), .fifo_flush_o(fifo_flush_o),
`ifdef FIFO_PUSH_SCHEDULER_STATS_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .busy_o(busy_o)
  );

  typedef struct {
    logic [NR-1:0]     ready;
    logic [IDW+DW-1:0] data;
    logic              flush;
    logic              busy;
    logic [31:0]       stall;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: occupancy per producer, rotating pointer, mode, and contents of the external FIFO.
  int          cnt_m[NR];
  int          ptr_m;
  int          mode_m;
  int          fq[$];
  logic [31:0] stall_m;

  task automatic model_clear();
    for (int i = 0; i < NR; i++) cnt_m[i] = 0;
    ptr_m   = 0;
    mode_m  = M_RUN;
    fq.delete();
    stall_m = '0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("req_ready", 64'(req_ready_o), 64'(e.ready));
      chk("fifo_push", 64'(fifo_push_o), 64'(|e.ready));
      chk("fifo_data", 64'(fifo_data_o), 64'(e.data));
      chk("fifo_flush", 64'(fifo_flush_o), 64'(e.flush));
      chk("busy", 64'(busy_o), 64'(e.busy));
`ifdef FIFO_PUSH_SCHEDULER_STATS_EN
      chk("stall_cnt", 64'(stall_cnt_o), 64'(e.stall));
`endif
    end
  end

  // One clock cycle: drive inputs, predict outputs, advance the model across the edge.
  task automatic step(input logic [NR-1:0] v, input bit pop, input bit drn,
                      input bit ffull, input bit rst, input bit spur);
    exp_t e;
    int   win, pid, j;
    bit   popped, emp;
    req_valid_i = v;
    for (int i = 0; i < NR; i++) req_data_i[i*DW +: DW] = $urandom;
    popped        = pop && (fq.size() > 0);
    pid           = popped ? fq[0] : 1;
    emp           = (fq.size() == 0);
    fifo_pop_i    = popped || spur;
    fifo_pop_id_i = pid[IDW-1:0];
    fifo_empty_i  = emp;
    fifo_full_i   = ffull || (fq.size() >= CAP);
    drain_i       = drn;
    rst_i         = rst;

    win = -1;
    if (mode_m == M_RUN && !fifo_full_i) begin
      for (int k = 0; k < NR; k++) begin
        j = (ptr_m + k) % NR;
        if (win < 0 && v[j] && cnt_m[j] < Q) win = j;
      end
    end
    e.ready = '0;
    e.data  = '0;
    if (win >= 0) begin
      e.ready[win] = 1'b1;
      e.data       = {win[IDW-1:0], req_data_i[win*DW +: DW]};
    end
    e.flush = (mode_m == M_FLUSH);
    e.busy  = (mode_m != M_RUN);
    e.stall = stall_m;
    sb.push_back(e);

    if (rst || mode_m == M_FLUSH) begin
      model_clear();
    end else begin
      if ((|v) && win < 0 && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
      if (fifo_pop_i) begin
        if (popped) void'(fq.pop_front());
        if (pid != win && cnt_m[pid] > 0) cnt_m[pid]--;
      end
      if (win >= 0) begin
        if (!(fifo_pop_i && pid == win)) cnt_m[win]++;
        ptr_m = (win + 1) % NR;
        fq.push_back(win);
      end
      if (mode_m == M_RUN && drn) mode_m = M_DRAIN;
      else if (mode_m == M_DRAIN && emp && !fifo_pop_i) mode_m = M_FLUSH;
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = '0; req_data_i = '0; fifo_full_i = 1'b0;
    fifo_empty_i = 1'b1; fifo_pop_i = 1'b0; fifo_pop_id_i = '0; drain_i = 1'b0;
    model_clear();
    @(posedge clk_i);
    #1;

    // Reset state, then fairness with pops keeping pace.
    repeat (2) step(4'h0, 0, 0, 0, 0, 0);
    repeat (6) step(4'hF, 1, 0, 0, 0, 0);

    // Spurious pop at zero occupancy, then quota on producer 1.
    step(4'h0, 0, 0, 0, 1, 0);
    step(4'h0, 0, 0, 0, 0, 1);
    repeat (4) step(4'b0010, 0, 0, 0, 0, 0);
    step(4'b0010, 1, 0, 0, 0, 0);
    repeat (3) step(4'b0010, 0, 0, 0, 0, 0);

    // Grant and pop to the same producer in one cycle.
    step(4'h0, 0, 0, 0, 1, 0);
    step(4'b0100, 0, 0, 0, 0, 0);
    step(4'b0100, 1, 0, 0, 0, 0);
    repeat (2) step(4'b0100, 0, 0, 0, 0, 0);

    // Drain with three entries queued, flush, resume.
    step(4'h0, 0, 0, 0, 1, 0);
    repeat (3) step(4'b0111, 0, 0, 0, 0, 0);
    step(4'h0, 0, 1, 0, 0, 0);
    repeat (2) step(4'hF, 0, 0, 0, 0, 0);
    repeat (3) step(4'hF, 1, 0, 0, 0, 0);
    repeat (3) step(4'hF, 0, 0, 0, 0, 0);

    // FIFO full stalls all producers and freezes the pointer.
    repeat (3) step(4'hF, 1, 0, 1, 0, 0);
    repeat (2) step(4'hF, 1, 0, 0, 0, 0);

    // Reset in the middle of a drain.
    repeat (2) step(4'hF, 0, 0, 0, 0, 0);
    step(4'h0, 0, 1, 0, 0, 0);
    step(4'hF, 0, 0, 0, 1, 0);
    repeat (3) step(4'hF, 1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step(4'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0, 1'b0);
    end

    for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk_i);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
